// File: rtl/ppu_reg_port_if.sv
// ============================================================================
// Module   : ppu_reg_port_if
// Brief    : CPU register bus and VRAM handshake bundle of the PPU register port.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ppu_reg_port_if #(
    parameter int ADDR_W = 14
);
    logic [2:0]        ri_sel_in;
    logic              ri_cs_in;
    logic              ri_r_nw_in;
    logic [7:0]        ri_d_in;
    logic [7:0]        ri_d_out;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic [ADDR_W-1:0] addr;
    logic              write_request;
    logic              read_request;
    logic              mem_ack_in;

    modport master (
        output ri_sel_in, ri_cs_in, ri_r_nw_in, ri_d_in, data_in, mem_ack_in,
        input  ri_d_out, data_out, addr, write_request, read_request
    );

    modport slave (
        input  ri_sel_in, ri_cs_in, ri_r_nw_in, ri_d_in, data_in, mem_ack_in,
        output ri_d_out, data_out, addr, write_request, read_request
    );
endinterface

`default_nettype wire

// File: rtl/ppu_reg_port.sv
// ============================================================================
// Module   : ppu_reg_port
// Brief    : PPU $2000-$2007 register file and VRAM req/ack access sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ppu_reg_port #(
    parameter int ADDR_W   = 14,
    parameter int PAL_BASE = 'h3F00,
    parameter int TIMEOUT  = 15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ppu_reg_port_if.slave    bus,
    input  wire logic        vblank_set_in,
    input  wire logic        vblank_clr_in,
    output logic [7:0]       ctrl_out,
    output logic [7:0]       mask_out,
    output logic [15:0]      scroll_out,
    output logic [7:0]       oam_addr_out,
    output logic             oam_we,
    output logic [7:0]       oam_d_out,
    input  wire logic [7:0]  oam_d_in,
    output logic             nmi_out,
    output logic             busy_out
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] PAL_ADDR = ADDR_W'(PAL_BASE);

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        ctrl_q, ctrl_d, mask_q, mask_d, oam_addr_q, oam_addr_d;
    logic [7:0]        oam_d_q, oam_d_d, rdbuf_q, rdbuf_d, ri_d_out_q, ri_d_out_d;
    logic [7:0]        data_out_q, data_out_d;
    logic [15:0]       scroll_q, scroll_d;
    logic [ADDR_W-1:0] v_q, v_d, t_q, t_d, addr_q, addr_d;
    logic              vblank_q, vblank_d, err_q, err_d, w_q, w_d;
    logic              oam_we_q, oam_we_d, pend_q, pend_d, rd_pal_q, rd_pal_d;

    logic              cpu_rd, cpu_wr, busy, done_ack, done_tmo;
    logic [ADDR_W-1:0] v_step, v_base, v_hi, v_lo;

    assign cpu_rd   = bus.ri_cs_in &  bus.ri_r_nw_in;
    assign cpu_wr   = bus.ri_cs_in & ~bus.ri_r_nw_in;
    assign busy     = (state_q != S_IDLE);
    assign done_ack = busy & bus.mem_ack_in;
    assign done_tmo = busy & ~bus.mem_ack_in & (cnt_q == TMO_W'(TIMEOUT - 1));
    assign v_step   = v_q + (ctrl_q[2] ? ADDR_W'(32) : ADDR_W'(1));
    // A $2006 write during a transaction accumulates in t until the transaction ends.
    assign v_base   = pend_q ? t_q : v_q;
    assign v_hi     = {bus.ri_d_in[ADDR_W-9:0], v_base[7:0]};
    assign v_lo     = {v_base[ADDR_W-1:8], bus.ri_d_in};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = ctrl_q;
        mask_d     = mask_q;
        oam_addr_d = oam_addr_q;
        oam_d_d    = oam_d_q;
        oam_we_d   = 1'b0;
        rdbuf_d    = rdbuf_q;
        ri_d_out_d = ri_d_out_q;
        data_out_d = data_out_q;
        scroll_d   = scroll_q;
        v_d        = v_q;
        t_d        = t_q;
        pend_d     = pend_q;
        addr_d     = addr_q;
        vblank_d   = vblank_q;
        err_d      = err_q;
        w_d        = w_q;
        rd_pal_d   = rd_pal_q;

        if (vblank_clr_in) begin
            vblank_d = 1'b0;
        end else if (vblank_set_in) begin
            vblank_d = 1'b1;
        end else if (cpu_rd && bus.ri_sel_in == 3'd2) begin
            vblank_d = 1'b0;
        end

        if (oam_we_q) begin
            oam_addr_d = oam_addr_q + 8'd1;
        end

        if (busy) begin
            if (bus.mem_ack_in) begin
                state_d = S_IDLE;
                if (state_q == S_RD) begin
                    rdbuf_d = bus.data_in;
                    if (rd_pal_q) begin
                        ri_d_out_d = bus.data_in;
                    end
                end
            end else if (done_tmo) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + TMO_W'(1);
            end
            if (done_ack || done_tmo) begin
                v_d    = pend_q ? t_q : v_step;
                pend_d = 1'b0;
            end
        end

        if (cpu_rd) begin
            case (bus.ri_sel_in)
                3'd2: begin
                    ri_d_out_d = {vblank_q & ~vblank_set_in, err_q, 6'b0};
                    err_d      = done_tmo;
                    w_d        = 1'b0;
                end
                3'd4: ri_d_out_d = oam_d_in;
                3'd7: begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = S_RD;
                        cnt_d    = '0;
                        addr_d   = v_q;
                        rd_pal_d = (v_q >= PAL_ADDR);
                        if (v_q < PAL_ADDR) begin
                            ri_d_out_d = rdbuf_q;
                        end
                    end
                end
                default: ri_d_out_d = 8'h00;
            endcase
        end

        if (cpu_wr) begin
            case (bus.ri_sel_in)
                3'd0: ctrl_d     = bus.ri_d_in;
                3'd1: mask_d     = bus.ri_d_in;
                3'd3: oam_addr_d = bus.ri_d_in;
                3'd4: begin
                    oam_we_d = 1'b1;
                    oam_d_d  = bus.ri_d_in;
                end
                3'd5: begin
                    if (w_q) scroll_d[15:8] = bus.ri_d_in;
                    else     scroll_d[7:0]  = bus.ri_d_in;
                    w_d = ~w_q;
                end
                3'd6: begin
                    w_d = ~w_q;
                    if (busy && !(done_ack || done_tmo)) begin
                        t_d    = w_q ? v_lo : v_hi;
                        pend_d = 1'b1;
                    end else begin
                        v_d    = w_q ? v_lo : v_hi;
                        pend_d = 1'b0;
                    end
                end
                3'd7: begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = S_WR;
                        cnt_d      = '0;
                        addr_d     = v_q;
                        data_out_d = bus.ri_d_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            mask_q     <= '0;
            oam_addr_q <= '0;
            oam_d_q    <= '0;
            oam_we_q   <= 1'b0;
            rdbuf_q    <= '0;
            ri_d_out_q <= '0;
            data_out_q <= '0;
            scroll_q   <= '0;
            v_q        <= '0;
            t_q        <= '0;
            pend_q     <= 1'b0;
            addr_q     <= '0;
            vblank_q   <= 1'b0;
            err_q      <= 1'b0;
            w_q        <= 1'b0;
            rd_pal_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            mask_q     <= mask_d;
            oam_addr_q <= oam_addr_d;
            oam_d_q    <= oam_d_d;
            oam_we_q   <= oam_we_d;
            rdbuf_q    <= rdbuf_d;
            ri_d_out_q <= ri_d_out_d;
            data_out_q <= data_out_d;
            scroll_q   <= scroll_d;
            v_q        <= v_d;
            t_q        <= t_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            vblank_q   <= vblank_d;
            err_q      <= err_d;
            w_q        <= w_d;
            rd_pal_q   <= rd_pal_d;
        end
    end

    assign bus.ri_d_out      = ri_d_out_q;
    assign bus.data_out      = data_out_q;
    assign bus.addr          = addr_q;
    assign bus.write_request = (state_q == S_WR);
    assign bus.read_request  = (state_q == S_RD);
    assign ctrl_out          = ctrl_q;
    assign mask_out          = mask_q;
    assign scroll_out        = scroll_q;
    assign oam_addr_out      = oam_addr_q;
    assign oam_we            = oam_we_q;
    assign oam_d_out         = oam_d_q;
    assign nmi_out           = ctrl_q[7] & vblank_q;
    assign busy_out          = busy;
endmodule

`default_nettype wire
